// File: rtl/alarm_clk_btn_pio_pkg.sv
// Shared definitions for the alarm_clk push-button PIO.
//   ADDR_*      : register addresses on the Avalon-MM slave
//   irq_mode_e  : interrupt source selection held in the MODE register
package alarm_clk_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MODE = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic [1:0] {
        IRQ_LEVEL = 2'd0,
        IRQ_RISE  = 2'd1,
        IRQ_FALL  = 2'd2,
        IRQ_BOTH  = 2'd3
    } irq_mode_e;

endpackage

// File: rtl/alarm_clk_btn_pio_if.sv
// Avalon-MM slave bundle for the push-button PIO.
//   address, chipselect, write_n, writedata : master -> slave
//   readdata, irq                           : slave -> master
// Handshake: there is no wait state. A write is accepted on any clk edge
// where chipselect=1 and write_n=0. readdata is registered from address on
// every edge, so it shows the addressed register one cycle after address is
// presented, independent of chipselect. irq is a level, active-high.
interface alarm_clk_btn_pio_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/alarm_clk_btn_pio_btn_debounce.sv
// One button channel: 2-flop synchroniser, optional inversion, debouncer.
//   clk, reset_n : clock, async active-low reset
//   pin          : raw asynchronous button pin
//   db           : debounced level (1 = pressed when INVERT=1)
//   db_next      : value db takes on the next edge, used for same-cycle edge detect
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit INVERT          = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic db,
    output logic db_next
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // The inversion is folded in ahead of the first flop so that the
    // zero-reset synchroniser reads "released" rather than "pressed" out of
    // reset; a pin held at reset then takes the full 2+DEBOUNCE_CYCLES to
    // register. A single inverter on an async input is glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= pin ^ INVERT;
            s2 <= s1;
        end
    end

    always_comb begin
        db_next  = db;
        cnt_next = cnt;
        if (s2 == db) begin
            cnt_next = '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            db_next  = s2;
            cnt_next = '0;
        end else begin
            cnt_next = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db  <= 1'b0;
            cnt <= '0;
        end else begin
            db  <= db_next;
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/alarm_clk_btn_pio.sv
// Multi-channel push-button input port, Avalon-MM slave.
//   clk, reset_n : clock, async active-low reset
//   bus          : Avalon-MM slave (address, chipselect, write_n, writedata,
//                  readdata, irq)
//   in_port      : raw asynchronous button pins
// Registers: 0 DATA (RO debounced levels), 1 MODE (irq source),
//            2 MASK (irq enables), 3 EDGE (write-1-to-clear edge capture).
module alarm_clk_btn_pio
    import alarm_clk_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit INVERT          = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    alarm_clk_btn_pio_if.slave  bus,
    input  logic [WIDTH-1:0]    in_port
);

    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] db_next;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    irq_mode_e        mode;
    logic [31:0]      readdata;
    logic [31:0]      rd_mux;
    logic             wr;
    // Write bits above each field width are don't-care.
    logic [31:0]      unused_wdata;

    assign unused_wdata = bus.writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (INVERT)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (in_port[i]),
            .db      (db[i]),
            .db_next (db_next[i])
        );
    end

    assign wr   = bus.chipselect & ~bus.write_n;
    assign rise = db_next & ~db;
    assign fall = ~db_next & db;
    assign clr  = (wr && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;

    always_comb begin
        ev = '0;
        case (mode)
            IRQ_RISE: ev = rise;
            IRQ_FALL: ev = fall;
            IRQ_BOTH: ev = rise | fall;
            default:  ev = '0;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = db;
            ADDR_MODE: rd_mux[1:0]       = mode;
            ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
            default:   rd_mux[WIDTH-1:0] = edge_cap;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode     <= IRQ_LEVEL;
            irq_mask <= '0;
            edge_cap <= '0;
            readdata <= '0;
        end else begin
            if (wr && bus.address == ADDR_MODE) begin
                mode <= irq_mode_e'(bus.writedata[1:0]);
            end
            if (wr && bus.address == ADDR_MASK) begin
                irq_mask <= bus.writedata[WIDTH-1:0];
            end
            // OR-ing ev after the clear makes a same-cycle event win.
            edge_cap <= (edge_cap & ~clr) | ev;
            readdata <= rd_mux;
        end
    end

    assign bus.readdata = readdata;
    assign bus.irq      = (mode == IRQ_LEVEL) ? |(db & irq_mask) : |(edge_cap & irq_mask);

endmodule

// File: tb/tb_alarm_clk_btn_pio.sv
module tb_alarm_clk_btn_pio;
    import alarm_clk_pio_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEB   = 8;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] in_port;

    alarm_clk_btn_pio_if bus();

    alarm_clk_btn_pio #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB),
        .INVERT          (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .in_port (in_port)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        do_wr;
        logic        wr_cs;
        logic [1:0]  wr_addr;
        logic [31:0] wdata;
        logic [1:0]  rd_addr;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks: called just after a negedge, return just after a negedge
    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data, input logic cs);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = cs;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        bus.address = addr;
        @(negedge clk);
        data = bus.readdata;
    endtask

    logic [31:0] rd;

    initial begin
        // register-map vectors, applied from reset with pins idle
        vecs[0]  = '{1'b0, 1'b1, ADDR_DATA, 32'h0,         ADDR_DATA, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, ADDR_DATA, 32'h0,         ADDR_MODE, 32'h0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, ADDR_DATA, 32'h0,         ADDR_MASK, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, ADDR_DATA, 32'h0,         ADDR_EDGE, 32'h0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, ADDR_MODE, 32'hFFFF_FFFD, ADDR_MODE, 32'h1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, ADDR_MASK, 32'hFFFF_FFF5, ADDR_MASK, 32'h5, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, ADDR_DATA, 32'h0000_000F, ADDR_DATA, 32'h0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, ADDR_EDGE, 32'h0000_000F, ADDR_EDGE, 32'h0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, ADDR_MODE, 32'h0000_0002, ADDR_MODE, 32'h2, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, ADDR_MODE, 32'h0000_0003, ADDR_MODE, 32'h3, 1'b0};
        vecs[10] = '{1'b1, 1'b1, ADDR_MASK, 32'h0000_0000, ADDR_MASK, 32'h0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, ADDR_MASK, 32'h0000_000F, ADDR_MASK, 32'h0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, ADDR_MODE, 32'h0000_0000, ADDR_MODE, 32'h0, 1'b0};

        // reset
        reset_n        = 1'b0;
        in_port        = '1;
        bus.address    = ADDR_DATA;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (3) @(negedge clk);
        check("reset_readdata", bus.readdata, 32'h0);
        check("reset_irq", {31'h0, bus.irq}, 32'h0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // table-driven register map
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].do_wr) bus_write(vecs[i].wr_addr, vecs[i].wdata, vecs[i].wr_cs);
            bus_read(vecs[i].rd_addr, rd);
            check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), {31'h0, bus.irq}, {31'h0, vecs[i].exp_irq});
        end

        // 1: press ch0, DATA bit0 visible 2+8 cycles + 1 readdata cycle later
        bus.address = ADDR_DATA;
        in_port[0]  = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check($sformatf("t1_data_c%0d", i), bus.readdata, (i >= 11) ? 32'h1 : 32'h0);
        end
        in_port[0] = 1'b1;
        repeat (12) @(negedge clk);

        // 2: 7-cycle glitches with 1-cycle gaps never reach db
        bus_write(ADDR_MODE, 32'h3, 1'b1);
        bus_write(ADDR_MASK, 32'hF, 1'b1);
        for (int r = 0; r < 3; r++) begin
            in_port[1] = 1'b0;
            repeat (7) @(negedge clk);
            check($sformatf("t2_irq_low%0d", r), {31'h0, bus.irq}, 32'h0);
            in_port[1] = 1'b1;
            @(negedge clk);
            check($sformatf("t2_irq_gap%0d", r), {31'h0, bus.irq}, 32'h0);
        end
        repeat (12) @(negedge clk);
        bus_read(ADDR_DATA, rd);
        check("t2_data", rd, 32'h0);
        bus_read(ADDR_EDGE, rd);
        check("t2_edge", rd, 32'h0);
        check("t2_irq", {31'h0, bus.irq}, 32'h0);

        // 3: rising capture on ch2, irq, W1C clear
        bus_write(ADDR_MODE, 32'h1, 1'b1);
        bus_write(ADDR_MASK, 32'h4, 1'b1);
        in_port[2] = 1'b0;
        repeat (12) @(negedge clk);
        bus_read(ADDR_EDGE, rd);
        check("t3_edge_set", rd, 32'h4);
        check("t3_irq_set", {31'h0, bus.irq}, 32'h1);
        bus_write(ADDR_EDGE, 32'h4, 1'b1);
        check("t3_irq_clr", {31'h0, bus.irq}, 32'h0);
        bus_read(ADDR_EDGE, rd);
        check("t3_edge_clr", rd, 32'h0);
        in_port[2] = 1'b1;
        repeat (12) @(negedge clk);
        bus_read(ADDR_EDGE, rd);
        check("t3_fall_ignored", rd, 32'h0);
        check("t3_irq_fall", {31'h0, bus.irq}, 32'h0);

        // 4: set wins over a same-cycle clear on ch3
        bus_write(ADDR_MODE, 32'h3, 1'b1);
        bus_write(ADDR_MASK, 32'h0, 1'b1);
        in_port[3] = 1'b0;
        repeat (9) @(negedge clk);
        bus_write(ADDR_EDGE, 32'h8, 1'b1);   // lands on the db edge
        bus_read(ADDR_EDGE, rd);
        check("t4_set_wins", rd, 32'h8);
        bus_write(ADDR_EDGE, 32'h8, 1'b1);
        bus_read(ADDR_EDGE, rd);
        check("t4_clr", rd, 32'h0);
        in_port[3] = 1'b1;
        repeat (12) @(negedge clk);
        bus_read(ADDR_EDGE, rd);
        check("t4_fall_cap", rd, 32'h8);
        bus_write(ADDR_EDGE, 32'hF, 1'b1);
        bus_read(ADDR_EDGE, rd);
        check("t4_clr_all", rd, 32'h0);

        // 5: level mode on ch0
        bus_write(ADDR_MODE, 32'h0, 1'b1);
        bus_write(ADDR_MASK, 32'h1, 1'b1);
        in_port[0] = 1'b0;
        repeat (12) @(negedge clk);
        check("t5_irq_held", {31'h0, bus.irq}, 32'h1);
        bus_read(ADDR_DATA, rd);
        check("t5_data", rd, 32'h1);
        in_port[0] = 1'b1;
        repeat (9) @(negedge clk);
        check("t5_irq_before_db", {31'h0, bus.irq}, 32'h1);
        @(negedge clk);
        check("t5_irq_released", {31'h0, bus.irq}, 32'h0);
        in_port[0] = 1'b0;
        repeat (12) @(negedge clk);
        check("t5_irq_again", {31'h0, bus.irq}, 32'h1);
        bus_write(ADDR_MASK, 32'h0, 1'b1);
        check("t5_irq_masked", {31'h0, bus.irq}, 32'h0);
        in_port[0] = 1'b1;
        repeat (12) @(negedge clk);

        // 6: reset mid-count with ch0 pressed
        in_port[1] = 1'b0;
        bus_write(ADDR_MASK, 32'h2, 1'b1);
        repeat (12) @(negedge clk);
        check("t6_irq_pre", {31'h0, bus.irq}, 32'h1);
        bus_read(ADDR_DATA, rd);
        check("t6_data_pre", rd, 32'h2);
        in_port[0] = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        reset_n    = 1'b0;
        in_port[1] = 1'b1;
        #1;
        check("t6_rd_in_reset", bus.readdata, 32'h0);
        check("t6_irq_in_reset", {31'h0, bus.irq}, 32'h0);
        repeat (2) @(negedge clk);
        check("t6_rd_in_reset2", bus.readdata, 32'h0);
        reset_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check($sformatf("t6_data_c%0d", i), bus.readdata, (i >= 11) ? 32'h1 : 32'h0);
        end
        check("t6_irq_post", {31'h0, bus.irq}, 32'h0);
        in_port[0] = 1'b1;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
